// File: rtl/data_hs_pkg.sv
// rtl/data_hs_pkg.sv - shared widths, count type and sizing helpers for the handshake FIFO
package data_hs_pkg;

    // Widest count any instance can report; per-instance counts are sliced from this.
    localparam int COUNT_MAX_W = 32;

    typedef logic [COUNT_MAX_W-1:0] count_t;

    // Address width for a power-of-two storage array.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_hs_ram.sv
// rtl/data_hs_ram.sv - DEPTH x WIDTH register array, one write port, asynchronous read
module data_hs_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry; reset clears every entry so the read port shows zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read is combinational so the head word falls through without an extra register stage.
    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/data_hs_fifo.sv
// rtl/data_hs_fifo.sv - valid/ready FIFO with first-word fall-through, occupancy and flush
module data_hs_fifo
    import data_hs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PW       = ptr_w(DEPTH);
    localparam count_t           DEPTH_C  = count_t'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH_C[CNT_W-1:0];
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready/valid come from the registered count only, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (count != FULL_CNT);
    assign out_valid_o = (count != '0);
    assign count_o     = count;

    // A flush cycle suppresses both transfers; the incoming word is dropped, not stored.
    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    data_hs_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (push),
        .waddr_i (wr_ptr),
        .wdata_i (in_data_i),
        .raddr_i (rd_ptr),
        .rdata_o (out_data_o)
    );

    // Pointer and occupancy bookkeeping; flush outranks push and pop, pointers roll over naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/data_hs_fifo.md
Name: data_hs_fifo

Overview:
Parametrised valid/ready handshake buffer, the successor to the single-register data_hs stage. It holds up to DEPTH words, so a producer and consumer can be decoupled by more than one beat while keeping full throughput (one transfer per cycle). It adds occupancy reporting and a synchronous flush. It sits between any two streaming blocks in the datapath.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 4, storage entries; power of two, >=2
CNT_W, $clog2(DEPTH+1), width of count_o (derived; not overridden)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
flush_i  input  1  synchronous flush, discards all stored words
in_data_i  input  WIDTH  upstream data
in_valid_i  input  1  upstream data valid
in_ready_o  output  1  buffer can accept a word this cycle
out_data_o  output  WIDTH  head-of-buffer data
out_valid_o  output  1  head-of-buffer data valid
out_ready_i  input  1  downstream accepts head word
count_o  output  CNT_W  number of stored words, 0..DEPTH

Behaviour:
- Reset (asynchronous, rst_n_i low): pointers 0, count_o=0, out_valid_o=0, in_ready_o=1, out_data_o=0, storage cleared to 0. Takes effect immediately, mid-transfer included; in-flight words are lost.
- Push = in_valid_i && in_ready_o. Pop = out_valid_o && out_ready_i.
- in_ready_o = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready_i.
- out_valid_o = (count != 0). out_data_o = storage[rd_ptr]. This is first-word fall-through from registered storage.
- Latency: a word pushed at edge N is presented on out_data_o with out_valid_o=1 in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: with in_valid_i=1 and out_ready_i=1 continuously, there is one transfer per cycle in steady state, with no bubbles.
- Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged. Data order is strictly FIFO.
- Full (count=DEPTH): in_ready_o=0, so no push. A pop that cycle makes in_ready_o=1 the next cycle. Same-cycle refill at full is not supported.
- Empty (count=0): out_valid_o=0, so no pop. A push that cycle produces valid output the next cycle. There is no bypass.
- Pointers wrap from DEPTH-1 to 0 (natural binary rollover, since DEPTH is a power of two).
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o hold unchanged.
- Upstream contract: in_data_i is held while in_valid_i && !in_ready_o. The block does not check this.
- flush_i=1 at edge N: pointers and count go to 0 after edge N. Any push or pop in that cycle is ignored (the input word is dropped). out_valid_o=0 and in_ready_o=1 from the cycle after. Flush has priority over push and pop.
- Storage is not cleared by flush. Only reset clears it.

Decomposition:
- Package data_hs_pkg holds:
  - function ptr_w(depth) returning $clog2(depth);
  - localparam-style helpers for CNT_W;
  - a typedef for count.
- Sub-module data_hs_ram: DEPTH x WIDTH register array with write port (we, waddr, wdata) and asynchronous read (raddr -> rdata), reset to 0.
- The top level holds pointers, count, the handshake logic and flush.

Test Plan:
1. Single word: after reset, push 0xDEADBEEF for one cycle with out_ready_i=1 -> next cycle out_valid_o=1 and out_data_o=0xDEADBEEF, count_o=1; the cycle after, out_valid_o=0 and count_o=0.
2. Fill/full: out_ready_i=0, in_valid_i=1 with data 0xDEADBEEF, 0xDEADBEF0, ... -> 4 accepted, then in_ready_o=0 and count_o=4, 5th word held off. Then set out_ready_i=1 -> outputs BEEF, BEF0, BEF1, BEF2, then BEF3, in order.
3. Throughput: in_valid_i=1 and out_ready_i=1 for 100 cycles, incrementing data -> after the first cycle, one word out per cycle with no gaps, count_o=1 constant, all 100 words correct.
4. Random backpressure: random in_valid_i and out_ready_i (50%), 1000 words, scoreboard -> no loss, duplication or reorder, and out_data_o stable while stalled.
5. Flush: count_o=3, flush_i=1 with in_valid_i=1 and data 0x12345678 -> next cycle count_o=0, out_valid_o=0, in_ready_o=1; 0x12345678 never appears.
6. Reset mid-operation: count_o=3, drive rst_n_i low between edges -> immediately count_o=0, out_valid_o=0, in_ready_o=1, out_data_o=0. After release, the case 1 sequence passes.
